// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - filtered quadrature decoder with wrapping position counter.
// Define QUAD_DECODER_ERROR_EN to add the sticky err output for double-bit transitions.
module quad_decoder #(
  parameter int WIDTH      = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic             clock_div,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             Up_Down,
  output logic             step
`ifdef QUAD_DECODER_ERROR_EN
  ,
  output logic             err
`endif
);

  localparam logic [3:0]       FILT = 4'(FILTER_LEN);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {UNPRIMED, PRIMED} state_t;

  state_t     state, state_nxt;
  logic [1:0] sync1, sync2, baseline;
  logic [3:0] stab_cnt;
  logic       stable, prime, accept, is_up, is_down;

  // Position in the Gray cycle 00,01,11,10 so direction is a +/-1 compare.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // sync1 holds the value sync2 takes next, so comparing them tracks sync2 stability.
  always_ff @(posedge clock_div) begin
    if (!reset) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      stab_cnt <= 4'd0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
      if (sync1 != sync2)
        stab_cnt <= 4'd0;
      else if (stab_cnt != 4'hF)
        stab_cnt <= stab_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock_div) begin
    if (!reset)
      state <= UNPRIMED;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    prime     = 1'b0;
    accept    = 1'b0;
    stable    = (stab_cnt >= FILT);
    case (state)
      UNPRIMED: begin
        if (stable) begin
          prime     = 1'b1;
          state_nxt = PRIMED;
        end
      end
      PRIMED: begin
        if (stable && (sync2 != baseline))
          accept = 1'b1;
      end
      default: state_nxt = UNPRIMED;
    endcase
    is_up   = accept && (gray_idx(sync2) == gray_idx(baseline) + 2'd1);
    is_down = accept && (gray_idx(baseline) == gray_idx(sync2) + 2'd1);
  end

  always_ff @(posedge clock_div) begin
    if (!reset)
      baseline <= 2'b00;
    else if (prime || accept)
      baseline <= sync2;
  end

  always_ff @(posedge clock_div) begin
    if (!reset) begin
      count   <= '0;
      Up_Down <= 1'b1;
      step    <= 1'b0;
    end else begin
      step <= is_up || is_down;
      if (clr)
        count <= '0;
      else if (is_up)
        count <= count + ONE;
      else if (is_down)
        count <= count - ONE;
      if (is_up)
        Up_Down <= 1'b1;
      else if (is_down)
        Up_Down <= 1'b0;
    end
  end

`ifdef QUAD_DECODER_ERROR_EN
  always_ff @(posedge clock_div) begin
    if (!reset)
      err <= 1'b0;
    else if (accept && !is_up && !is_down)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder.
module tb_quad_decoder;

  localparam int W = 4;
  localparam int F = 3;

  logic         clock_div = 1'b0;
  logic         reset;
  logic         enc_a, enc_b, clr;
  logic [W-1:0] count;
  logic         Up_Down, step;
`ifdef QUAD_DECODER_ERROR_EN
  logic         err;
`endif

  typedef struct {
    logic [W-1:0] cnt;
    logic         ud;
    int           edge_n;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           edge_cnt = 0;
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] m_count;
  logic         m_ud;
  logic         m_err;
  logic [1:0]   model_ab;
  int           se;
  logic [1:0]   fwd[4];

  quad_decoder #(.WIDTH(W), .FILTER_LEN(F)) dut (
    .clock_div(clock_div),
    .reset    (reset),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .clr      (clr),
    .count    (count),
    .Up_Down  (Up_Down),
    .step     (step)
`ifdef QUAD_DECODER_ERROR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clock_div = ~clock_div;
  always @(posedge clock_div) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_up(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new level; push the expected step (if any) with its edge number.
  task automatic move(input logic [1:0] ab, input logic with_clr, output int step_edge);
    exp_t e;
    logic pushed;
    pushed    = 1'b0;
    step_edge = edge_cnt + F + 3;
    {enc_a, enc_b} = ab;
    if (ab == next_up(model_ab)) begin
      m_count = m_count + 4'd1;
      m_ud    = 1'b1;
      pushed  = 1'b1;
    end else if (model_ab == next_up(ab)) begin
      m_count = m_count - 4'd1;
      m_ud    = 1'b0;
      pushed  = 1'b1;
    end else if (ab != model_ab) begin
      m_err = 1'b1;
    end
    if (with_clr) m_count = '0;
    model_ab = ab;
    if (pushed) begin
      e.cnt    = m_count;
      e.ud     = m_ud;
      e.edge_n = step_edge;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock_div);
    reset    = 1'b1;
    m_count  = '0;
    m_ud     = 1'b1;
    m_err    = 1'b0;
    model_ab = {enc_a, enc_b};
    repeat (10) @(negedge clock_div);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, count, m_count);
    check({tag, "_dir"}, Up_Down, m_ud);
    check({tag, "_pending"}, sb.size(), 0);
`ifdef QUAD_DECODER_ERROR_EN
    check({tag, "_err"}, err, m_err);
`endif
  endtask

  always @(negedge clock_div) begin
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("step_count", count, mon_e.cnt);
        check("step_dir", Up_Down, mon_e.ud);
        check("step_edge", edge_cnt, mon_e.edge_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd = '{2'b01, 2'b11, 2'b10, 2'b00};
    reset = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    clr   = 1'b0;
    m_count = '0; m_ud = 1'b1; m_err = 1'b0; model_ab = 2'b00;
    repeat (3) @(negedge clock_div);
    check("rst_count", count, 0);
    check("rst_dir", Up_Down, 1);
    check("rst_step", step, 0);
`ifdef QUAD_DECODER_ERROR_EN
    check("rst_err", err, 0);
`endif
    reset = 1'b1;
    repeat (10) @(negedge clock_div);
    check_state("primed");

    for (int i = 0; i < 4; i++) begin
      move(fwd[i], 1'b0, se);
      repeat (10) @(negedge clock_div);
    end
    check_state("fwd4");

    do_reset();
    move(2'b10, 1'b0, se);
    repeat (10) @(negedge clock_div);
    check_state("rev_wrap");
    move(2'b00, 1'b0, se);
    repeat (10) @(negedge clock_div);
    check_state("fwd_wrap");
    move(2'b01, 1'b0, se);
    repeat (10) @(negedge clock_div);
    check_state("fwd_one");

    enc_a = 1'b1;
    repeat (2) @(negedge clock_div);
    enc_a = 1'b0;
    repeat (10) @(negedge clock_div);
    check_state("glitch");

    move(2'b10, 1'b0, se);
    repeat (10) @(negedge clock_div);
    check_state("double");
    clr = 1'b1;
    @(negedge clock_div);
    clr = 1'b0;
    m_count = '0;
    @(negedge clock_div);
    check_state("clr");

    move(2'b11, 1'b1, se);
    while (edge_cnt < se - 1) @(negedge clock_div);
    clr = 1'b1;
    @(negedge clock_div);
    clr = 1'b0;
    repeat (10) @(negedge clock_div);
    check_state("clr_step");

    {enc_a, enc_b} = 2'b00;
    do_reset();
    se = edge_cnt + F + 3;
    {enc_a, enc_b} = 2'b01;
    while (edge_cnt < se - 1) @(negedge clock_div);
    reset = 1'b0;
    @(negedge clock_div);
    reset    = 1'b1;
    m_count  = '0;
    m_ud     = 1'b1;
    m_err    = 1'b0;
    model_ab = 2'b01;
    repeat (10) @(negedge clock_div);
    check_state("mid_reset");
    move(2'b11, 1'b0, se);
    repeat (10) @(negedge clock_div);
    check_state("reprime");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning position counter width in bits.
REQ-002 SHALL have parameter FILTER_LEN, default 3, meaning consecutive stable samples (1..15) required to accept a new input level.
REQ-003 SHALL have port clock_div  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock_div.
REQ-005 SHALL have port enc_a  input  1  raw encoder channel A; asynchronous to clock_div.
REQ-006 SHALL have port enc_b  input  1  raw encoder channel B; asynchronous to clock_div.
REQ-007 SHALL have port clr  input  1  synchronous clear of count only.
REQ-008 SHALL have port count  output  WIDTH  signed-agnostic position, wraps modulo 2^WIDTH.
REQ-009 SHALL have port Up_Down  output  1  direction of last accepted step; 1 = up, 0 = down.
REQ-010 SHALL have port step  output  1  one-cycle pulse per accepted step.
REQ-011 SHALL have port err  output  1  sticky illegal-transition flag (present only per REQ-030).

Function
REQ-012 SHALL pass enc_a and enc_b each through a two-flop synchronizer before any other use.
REQ-013 SHALL keep a per-pair stability counter: increments while synchronized {a,b} is unchanged from the previous cycle, restarts at 0 on any change.
REQ-014 SHALL, after reset, hold state UNPRIMED: when synchronized {a,b} stays stable FILTER_LEN cycles, load it as baseline, enter PRIMED, and emit no step.
REQ-015 SHALL, in PRIMED, accept synchronized {a,b} as new filtered state once stable FILTER_LEN cycles and different from baseline; then baseline <= new value.
REQ-016 SHALL classify accepted transitions on Gray sequence 00->01->11->10->00 as up, reverse order as down.
REQ-017 SHALL, on up: count <= count+1 (2^WIDTH-1 wraps to 0), Up_Down <= 1, step high one cycle.
REQ-018 SHALL, on down: count <= count-1 (0 wraps to 2^WIDTH-1), Up_Down <= 0, step high one cycle.
REQ-019 SHALL, on double-bit transition (00<->11, 01<->10): update baseline, leave count and Up_Down unchanged, no step.
REQ-020 SHALL register count, Up_Down and step; step and count change on the same edge.
REQ-021 SHALL produce step exactly FILTER_LEN+2 clock_div edges after the first edge sampling a new, thereafter stable, raw level.
REQ-022 SHALL ignore glitches shorter than FILTER_LEN synchronized cycles (no baseline change, no step).
REQ-023 SHALL give clr priority over step on count: clr with a valid step -> count = 0, step still pulses, Up_Down still updates.
REQ-024 SHALL hold all outputs stable when no transition is accepted and clr is low.

Reset
REQ-025 SHALL, on reset low at a rising edge: count = 0, Up_Down = 1, step = 0, err = 0.
REQ-026 SHALL, on reset, clear synchronizers to 00, stability counter to 0, baseline to 00, state to UNPRIMED.
REQ-027 SHALL give reset priority over clr and all transitions, including mid-filter or mid-step.
REQ-028 SHALL require re-priming per REQ-014 after every reset release.

Configuration
REQ-029 SHALL use macro QUAD_DECODER_ERROR_EN to include/exclude illegal-transition detection.
REQ-030 SHALL, with QUAD_DECODER_ERROR_EN defined: set err = 1 on any REQ-019 transition in PRIMED, hold until reset (clr does not clear it).
REQ-031 SHALL, without QUAD_DECODER_ERROR_EN: omit err port and its logic; REQ-019 behaviour otherwise unchanged.

Verification
REQ-032 SHALL cover: reset, inputs held 00 for 10 cycles, then four forward Gray steps spaced 10 cycles -> 4 step pulses, count=4, Up_Down=1, each step FILTER_LEN+2 edges after raw change.
REQ-033 SHALL cover: from count=0 one reverse step (00->10) -> count=4'hF, Up_Down=0, single step pulse.
REQ-034 SHALL cover: from count=4'hF one forward step -> count=0, wrap, Up_Down=1.
REQ-035 SHALL cover: 2-cycle pulse on enc_a with FILTER_LEN=3 -> no step, count unchanged, err=0.
REQ-036 SHALL cover: enc_a and enc_b toggled together 00->11 with macro defined -> no step, count unchanged, err=1 until reset; clr leaves err=1.
REQ-037 SHALL cover: reset asserted one cycle before an expected step, inputs left at 01 -> no step, count=0, first subsequent stable 01 primes without step.
